// File: rtl/cam_capture_pkg.sv
// Shared frame geometry and RGB444 layout for the camera capture path,
// the frame buffer's reserved-black address and the VGA read side.
package cam_capture_pkg;

  localparam int FRAME_W    = 160;
  localparam int FRAME_H    = 120;
  localparam int FRAME_NPIX = FRAME_W * FRAME_H;

  // RGB444 word layout: R in the top nibble, B in the bottom nibble
  localparam int RGB_DW    = 12;
  localparam int RGB_R_MSB = 11;
  localparam int RGB_R_LSB = 8;
  localparam int RGB_G_MSB = 7;
  localparam int RGB_G_LSB = 4;
  localparam int RGB_B_MSB = 3;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_VS_HIGH,
    ST_BYTE_HI,
    ST_BYTE_LO
  } cap_state_t;

endpackage

// File: rtl/cam_capture_rgb565_to_444.sv
// Packs one RGB565 pixel, delivered as two camera bytes, into RGB444 by
// keeping the top four bits of each colour channel.
module rgb565_to_444
  import cam_capture_pkg::*;
(
  input  logic [7:0]        i_hi,
  input  logic [7:0]        i_lo,
  output logic [RGB_DW-1:0] o_pix
);

  // Low-order colour bits are dropped on purpose; gathered here so the
  // truncation is visible rather than silently ignored.
  logic w_unused;
  assign w_unused = ^{i_hi[3], i_lo[6:5], i_lo[0]};

  // hi = RRRRRGGG, lo = GGGBBBBB; take R[4:1], G[5:2], B[4:1]
  always_comb begin
    o_pix = '0;
    o_pix[RGB_R_MSB:RGB_R_LSB] = i_hi[7:4];
    o_pix[RGB_G_MSB:RGB_G_LSB] = {i_hi[2:0], i_lo[7]};
    o_pix[RGB_B_MSB:RGB_B_LSB] = i_lo[4:1];
  end

endmodule

// File: rtl/cam_capture.sv
// OV7670 capture stage: frames the 8-bit pixel bus with VSYNC/HREF,
// packs byte pairs into RGB444 and writes them linearly into the frame
// buffer, never touching the reserved address NPIX.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int AW   = 15,
  parameter int DW   = RGB_DW,
  parameter int NPIX = FRAME_NPIX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic          capture_en,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          busy,
  output logic          err_odd,
  output logic          err_ovf
);

  localparam logic [AW-1:0] LP_ADDR_LIMIT = AW'(NPIX);

  cap_state_t      r_state;
  logic [7:0]      r_hi;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic            r_regwrite;
  logic            r_frame_done;
  logic            r_err_odd;
  logic            r_err_ovf;

  logic [RGB_DW-1:0] w_pix;
  logic              w_at_limit;

  rgb565_to_444 u_pack (
    .i_hi  (r_hi),
    .i_lo  (px_data),
    .o_pix (w_pix)
  );

  assign w_at_limit = (r_addr == LP_ADDR_LIMIT);

  assign addr_in    = r_addr;
  assign data_in    = r_data;
  assign regwrite   = r_regwrite;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_IDLE);
  assign err_odd    = r_err_odd;
  assign err_ovf    = r_err_ovf;

  // Framing FSM with the address counter, write strobe and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hi         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_regwrite   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_odd    <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_regwrite   <= 1'b0;
      r_frame_done <= 1'b0;

      // The address advances the cycle after each write pulse, so the
      // buffer sees the write at the address it was issued for.
      if (r_regwrite) begin
        r_addr <= r_addr + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (capture_en) begin
            r_err_odd <= 1'b0;
            r_err_ovf <= 1'b0;
            r_state   <= ST_WAIT_VS;
          end
        end

        ST_WAIT_VS: begin
          if (vsync) begin
            r_state <= ST_VS_HIGH;
          end
        end

        ST_VS_HIGH: begin
          if (!vsync) begin
            r_addr  <= '0;
            r_state <= ST_BYTE_HI;
          end
        end

        ST_BYTE_HI: begin
          if (vsync) begin
            r_frame_done <= 1'b1;
            r_state      <= capture_en ? ST_VS_HIGH : ST_IDLE;
          end else if (href) begin
            r_hi    <= px_data;
            r_state <= ST_BYTE_LO;
          end
        end

        ST_BYTE_LO: begin
          if (vsync) begin
            r_err_odd    <= 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= capture_en ? ST_VS_HIGH : ST_IDLE;
          end else if (href) begin
            if (w_at_limit) begin
              r_err_ovf <= 1'b1;
            end else begin
              r_regwrite <= 1'b1;
              r_data     <= w_pix;
            end
            r_state <= ST_BYTE_HI;
          end else begin
            r_err_odd <= 1'b1;
            r_state   <= ST_BYTE_HI;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
